// File: rtl/i2c_segment_mux.sv
// i2c_segment_mux: write-only I2C slave that loads digit/control registers and drives a
// time-multiplexed 7-segment display. Define HEX_DECODE_EN for hex glyph decode, else raw bytes.
module i2c_segment_mux #(
  parameter int         NUM_DIGITS = 4,
  parameter logic [6:0] I2C_ADDR   = 7'h42,
  parameter int         SCAN_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [2:0]            o_dbg_state
);
  localparam int            IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int            PW          = $clog2(SCAN_DIV);
  localparam logic [7:0]    LP_CTRL     = 8'(NUM_DIGITS);
  localparam logic [7:0]    LP_WADDR    = {I2C_ADDR, 1'b0};
  localparam logic [IW-1:0] LP_LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LP_LAST_PRE = PW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_scl_sync, r_sda_sync;
  logic          r_scl_d, r_sda_d;
  logic          w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift, w_byte, r_ptr;
  logic          r_ack, w_ack_nxt, r_sda_oe, w_oe_nxt;
  logic          w_ptr_ok, w_in_byte;
  logic [7:0]    r_digit [NUM_DIGITS];
  logic          r_blank;
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic          r_live;
  logic [7:0]    w_cur, w_glyph;
  logic          w_show;

  // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_ptr_ok   = (r_ptr <= LP_CTRL);
  assign w_in_byte  = (r_state == S_ADDR) || (r_state == S_PTR) || (r_state == S_DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_sda_oe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_ack_nxt;
      r_sda_oe <= w_oe_nxt;
    end
  end

  // Byte states advance on the SCL fall after the 8th sample; ACK states end on the next fall.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR:
          if (w_scl_fall && r_bit_cnt == 4'd8)
            w_state_nxt = (r_shift == LP_WADDR) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (w_scl_fall) w_state_nxt = S_PTR;
        S_PTR:      if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = S_PTR_ACK;
        S_PTR_ACK:  if (w_scl_fall) w_state_nxt = S_DATA;
        S_DATA:
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_state_nxt = S_DATA_ACK;
            w_ack_nxt   = w_ptr_ok;
          end
        S_DATA_ACK: if (w_scl_fall) w_state_nxt = S_DATA;
        default: ;
      endcase
    end
    w_oe_nxt = (w_state_nxt == S_ADDR_ACK) || (w_state_nxt == S_PTR_ACK) ||
               ((w_state_nxt == S_DATA_ACK) && w_ack_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_blank   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
    end else begin
      if (w_start || (w_state_nxt != r_state)) begin
        r_bit_cnt <= '0;
      end else if (w_in_byte && w_scl_rise && r_bit_cnt != 4'd8) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (r_state == S_PTR && w_state_nxt == S_PTR_ACK) r_ptr <= r_shift;
      if (r_state == S_DATA && w_state_nxt == S_DATA_ACK && w_ptr_ok)
        r_ptr <= (r_ptr == LP_CTRL) ? 8'd0 : r_ptr + 8'd1;
      // Register write lands on the rising edge that samples the last data bit.
      if (r_state == S_DATA && w_scl_rise && r_bit_cnt == 4'd7 && w_ptr_ok) begin
        if (r_ptr == LP_CTRL) r_blank <= w_byte[0];
        for (int i = 0; i < NUM_DIGITS; i++)
          if (r_ptr == 8'(i)) r_digit[i] <= w_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (ena) begin
        if (r_presc == LP_LAST_PRE) begin
          r_presc <= '0;
          r_idx   <= (r_idx == LP_LAST_IDX) ? '0 : r_idx + IW'(1);
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  always_comb begin
    w_cur = r_digit[0];
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_idx == IW'(i)) w_cur = r_digit[i];
  end

`ifdef HEX_DECODE_EN
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction
  assign w_glyph = {w_cur[7], hex7(w_cur[3:0])};
`else
  assign w_glyph = w_cur;
`endif

  // r_live keeps the display dark through the reset cycle itself.
  assign w_show      = r_live & ena & ~r_blank;
  assign seg_out     = w_show ? w_glyph : 8'h00;
  assign dig_sel     = w_show ? (NUM_DIGITS'(1) << r_idx) : '0;
  assign sda_oe      = r_sda_oe;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_i2c_segment_mux.sv
// tb_i2c_segment_mux: bit-banged I2C master driving i2c_segment_mux, with a register and
// scan reference model; ACKs are scoreboarded and the display is monitored in idle windows.
`timescale 1ns/1ps
module tb_i2c_segment_mux;
  localparam int         NUM   = 4;
  localparam logic [6:0] ADDR  = 7'h42;
  localparam int         SDIV  = 4;
  localparam int         T     = 4;
  localparam logic [7:0] WADDR = {ADDR, 1'b0};

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b1;
  logic           scl_m = 1'b1;
  logic           sda_m = 1'b1;
  logic           sda_line;
  logic           sda_oe;
  logic [7:0]     seg_out;
  logic [NUM-1:0] dig_sel;
  logic [2:0]     dbg_state;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_segment_mux #(.NUM_DIGITS(NUM), .I2C_ADDR(ADDR), .SCAN_DIV(SDIV)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .seg_out(seg_out), .dig_sel(dig_sel), .o_dbg_state(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_digit [NUM];
  logic       m_blank;
  int         m_ptr;
  int         m_ticks;
  logic       m_live;
  logic       mon_en = 1'b0;
  logic [7:0] tx_buf [16];
  logic [0:0] exp_q [$];

  function automatic logic [7:0] glyph(input logic [7:0] v);
`ifdef HEX_DECODE_EN
    logic [6:0] g;
    case (v[3:0])
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return {v[7], g};
`else
    return v;
`endif
  endfunction

  // Enabled clock count since reset; the displayed digit is that count divided into slots.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ticks <= 0;
      m_live  <= 1'b0;
    end else begin
      m_live <= 1'b1;
      if (ena) m_ticks <= m_ticks + 1;
    end
  end

  always @(negedge clk) begin
    int             idx;
    logic           on;
    logic [7:0]     e_seg;
    logic [NUM-1:0] e_dig;
    if (mon_en) begin
      idx   = (m_ticks / SDIV) % NUM;
      on    = m_live && ena && !m_blank;
      e_dig = on ? NUM'(1 << idx) : '0;
      e_seg = on ? glyph(m_digit[idx]) : 8'h00;
      n_tests++;
      if (seg_out !== e_seg || dig_sel !== e_dig || sda_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL display t=%0t seg=%h dig=%b oe=%b expected seg=%h dig=%b oe=0",
                 $time, seg_out, dig_sel, sda_oe, e_seg, e_dig);
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM; i++) m_digit[i] = 8'h00;
    m_blank = 1'b0;
    m_ptr   = 0;
  endfunction

  function automatic void model_txn(input int n);
    logic match;
    match = (tx_buf[0] == WADDR);
    exp_q.push_back(match);
    for (int i = 1; i < n; i++) begin
      if (!match) begin
        exp_q.push_back(1'b0);
      end else if (i == 1) begin
        m_ptr = int'(tx_buf[1]);
        exp_q.push_back(1'b1);
      end else if (m_ptr <= NUM) begin
        if (m_ptr == NUM) m_blank = tx_buf[i][0];
        else m_digit[m_ptr] = tx_buf[i];
        m_ptr = (m_ptr == NUM) ? 0 : m_ptr + 1;
        exp_q.push_back(1'b1);
      end else begin
        exp_q.push_back(1'b0);
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic observe(input int n);
    @(posedge clk);
    mon_en = 1'b1;
    repeat (n) @(negedge clk);
    @(posedge clk);
    mon_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(T);
    scl_m = 1'b1; wait_clks(T);
    sda_m = 1'b0; wait_clks(T);
    scl_m = 1'b0; wait_clks(T);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(T);
    scl_m = 1'b1; wait_clks(T);
    sda_m = 1'b1; wait_clks(T);
  endtask

  task automatic send_bit(input logic b, output logic oe_seen);
    sda_m = b;    wait_clks(T);
    scl_m = 1'b1; wait_clks(T);
    oe_seen = sda_oe;
    wait_clks(T);
    scl_m = 1'b0; wait_clks(T);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic stray);
    logic oe;
    stray = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], oe);
      stray = stray | oe;
    end
    send_bit(1'b1, ack);
  endtask

  task automatic i2c_txn(input int n, input logic do_stop);
    logic a, bad, e;
    model_txn(n);
    i2c_start();
    for (int i = 0; i < n; i++) begin
      send_byte(tx_buf[i], a, bad);
      e = exp_q.pop_front();
      n_tests++;
      if (a !== e || bad !== 1'b0) begin
        n_fail++;
        $display("FAIL ack byte%0d=%h got ack=%b stray_oe=%b expected ack=%b stray_oe=0",
                 i, tx_buf[i], a, bad, e);
      end
    end
    if (do_stop) i2c_stop();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    wait_clks(3);
    n_tests++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b expected 0", sda_oe); end
    n_tests++;
    if (seg_out !== 8'h00) begin n_fail++; $display("FAIL reset_seg got %h expected 00", seg_out); end
    n_tests++;
    if (dig_sel !== '0) begin n_fail++; $display("FAIL reset_dig got %b expected 0000", dig_sel); end
    rst_n = 1'b1;
    wait_clks(1);
    n_tests++;
    if (dig_sel !== 4'b0001 || seg_out !== glyph(8'h00)) begin
      n_fail++;
      $display("FAIL first_cycle got dig=%b seg=%h expected dig=0001 seg=%h",
               dig_sel, seg_out, glyph(8'h00));
    end
    observe(2 * NUM * SDIV);
  endtask

  task automatic test_spec_writes();
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h00; tx_buf[2] = 8'h05;
    i2c_txn(3, 1'b1);
    observe(NUM * SDIV + 2);
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h03; tx_buf[2] = 8'hAA; tx_buf[3] = 8'h01; tx_buf[4] = 8'h3F;
    i2c_txn(5, 1'b1);
    observe(NUM * SDIV + 2);
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h04; tx_buf[2] = 8'h00;
    i2c_txn(3, 1'b1);
    observe(2 * NUM * SDIV);
  endtask

  task automatic test_bad_addr();
    tx_buf[0] = 8'h86; tx_buf[1] = 8'h01; tx_buf[2] = 8'h55; tx_buf[3] = 8'h66;
    i2c_txn(4, 1'b1);
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h00; tx_buf[2] = 8'h77;
    i2c_txn(3, 1'b1);
    observe(NUM * SDIV + 2);
  endtask

  task automatic test_bad_ptr();
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h07; tx_buf[2] = 8'h12;
    i2c_txn(3, 1'b1);
    tx_buf[0] = 8'h84; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h34; tx_buf[3] = 8'h56;
    i2c_txn(4, 1'b1);
    observe(NUM * SDIV + 2);
  endtask

  task automatic test_repeated_start();
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h01; tx_buf[2] = 8'hC3;
    i2c_txn(3, 1'b0);
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h02; tx_buf[2] = 8'h5A; tx_buf[3] = 8'hE7;
    i2c_txn(4, 1'b1);
    observe(NUM * SDIV + 2);
  endtask

  task automatic test_ena();
    ena = 1'b0;
    observe(2 * SDIV + 3);
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h00; tx_buf[2] = 8'h9C;
    i2c_txn(3, 1'b1);
    observe(SDIV + 1);
    ena = 1'b1;
    observe(2 * NUM * SDIV + 3);
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(1, 6);
      tx_buf[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : WADDR;
      tx_buf[1] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, NUM + 1));
      for (int j = 2; j < n; j++) tx_buf[j] = 8'($urandom);
      i2c_txn(n, 1'b1);
      observe(NUM * SDIV + 2);
    end
  endtask

  task automatic test_reset_midbyte();
    logic a, bad, oe;
    i2c_start();
    send_byte(8'h84, a, bad);
    n_tests++;
    if (a !== 1'b1) begin n_fail++; $display("FAIL mid_addr_ack got %b expected 1", a); end
    send_byte(8'h01, a, bad);
    n_tests++;
    if (a !== 1'b1) begin n_fail++; $display("FAIL mid_ptr_ack got %b expected 1", a); end
    send_bit(1'b1, oe); send_bit(1'b0, oe); send_bit(1'b1, oe); send_bit(1'b0, oe);
    rst_n = 1'b0;
    model_reset();
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(1);
    n_tests++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL mid_reset_oe got %b expected 0", sda_oe); end
    sda_m = 1'b1; wait_clks(T);
    scl_m = 1'b1; wait_clks(T);
    observe(NUM * SDIV + 2);
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h00; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22;
    tx_buf[4] = 8'h33; tx_buf[5] = 8'h44; tx_buf[6] = 8'h00;
    i2c_txn(7, 1'b1);
    observe(2 * NUM * SDIV);
  endtask

  initial begin
    test_reset();
    test_spec_writes();
    test_bad_addr();
    test_bad_ptr();
    test_repeated_start();
    test_ena();
    test_random();
    test_reset_midbyte();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_segment_mux.md
I2C_SEGMENT_MUX -- requirements
Module: i2c_segment_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter I2C_ADDR, default 7'h42, 7-bit slave address.
REQ-003 Parameter SCAN_DIV, default 1000, clk cycles per digit slot; minimum 2.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ena  input  1  design enable.
REQ-007 scl_in  input  1  I2C clock, asynchronous.
REQ-008 sda_in  input  1  I2C data, asynchronous.
REQ-009 sda_oe  output  1  1 = pull SDA low (open drain); never drives high.
REQ-010 seg_out  output  8  segments, active-high; bit0..6 = a..g, bit7 = dp.
REQ-011 dig_sel  output  NUM_DIGITS  one-hot digit enable, active-high.

Function
REQ-012 scl_in and sda_in SHALL each pass a 2-flop synchronizer; edges are detected on synchronized values.
REQ-013 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both are recognised in every state.
REQ-014 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 START in any state -> ADDR with bit counter cleared (repeated START included); STOP in any state -> IDLE.
REQ-016 Bits SHALL be sampled on SCL rising edge, MSB first.
REQ-017 Address byte matching {I2C_ADDR, 0} -> ADDR_ACK; any other byte, including a read request, -> IGNORE with no ACK.
REQ-018 ACK: sda_oe = 1 from the SCL falling edge after the 8th bit until the next SCL falling edge; 0 otherwise.
REQ-019 First byte after address SHALL load the register pointer and is always ACKed.
REQ-020 Register map: 0..NUM_DIGITS-1 = digit registers (8 bit); NUM_DIGITS = control register (bit0 = blank; other bits read as 0).
REQ-021 Each DATA byte with pointer <= NUM_DIGITS SHALL be written when its 8th bit is sampled, then ACKed; pointer then increments, wrapping from NUM_DIGITS to 0.
REQ-022 Pointer > NUM_DIGITS: data bytes are NACKed, no register changes, pointer unchanged.
REQ-023 Scan: prescaler counts 0..SCAN_DIV-1; on wrap, digit index advances, wrapping NUM_DIGITS-1 -> 0.
REQ-024 seg_out = glyph(digit register[index]); dig_sel = 1 << index; change in the same cycle as the index.
REQ-025 blank = 1 or ena = 0 SHALL force seg_out = 0 and dig_sel = 0; ena = 0 also freezes the prescaler and index; I2C is unaffected by ena.
REQ-026 A write to the currently displayed digit SHALL appear on seg_out on the next clk cycle.

Reset
REQ-027 While rst_n = 0 at a clk edge: FSM = IDLE, sda_oe = 0, all digit registers = 0x00, control = 0x00, pointer = 0, prescaler = 0, index = 0, seg_out = 0, dig_sel = 0.
REQ-028 First cycle after release: dig_sel = 1 (digit 0); a transaction interrupted by reset is discarded; the bus is re-acquired only on a new START.

Configuration
REQ-029 Macro HEX_DECODE_EN defined: glyph = hex decode of bits[3:0] (0-F, standard 7-segment), bit7 -> dp, bits[6:4] ignored.
REQ-030 HEX_DECODE_EN undefined: glyph = raw register byte; no decoder is synthesized.

Verification
REQ-031 Write addr 0x84, ptr 0x00, data 0x05 (HEX_DECODE_EN) -> three ACKs; digit 0 shows seg_out = 0x6D while dig_sel = 0001.
REQ-032 Write addr 0x84, ptr 0x03, data 0xAA, 0x01, 0x3F (NUM_DIGITS = 4, raw mode) -> digit3 = 0xAA, control blank = 1 (outputs 0), digit0 = 0x3F after wrap.
REQ-033 Address 0x86 or 0x85 -> no ACK on any byte; all registers unchanged.
REQ-034 ptr 0x07 then data 0x12 -> byte NACKed; registers unchanged.
REQ-035 SCAN_DIV = 4, ena = 1 -> dig_sel 0001, 0010, 0100, 1000, 0001, each held for 4 clks; ena = 0 -> outputs 0, scan resumes from the frozen index.
REQ-036 rst_n low after 4 data bits of a byte, then released -> sda_oe = 0, all registers 0x00; the following full write succeeds.
